// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone constants and the copy-master state encoding.
package wb_pkg;
  localparam int WB_DW = 32;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, FIN} copy_state_e;
endpackage

// File: rtl/wb_if.sv
// wb_if: Wishbone classic bus bundle with master/slave views.
interface wb_if
  import wb_pkg::*;
#(parameter int ADDR_WIDTH = 32);
  logic cyc, stb, we, ack, err;
  logic [ADDR_WIDTH-1:0] adr;
  logic [3:0] sel;
  logic [WB_DW-1:0] mosi, miso;
  modport master(output cyc, stb, we, adr, sel, mosi, input miso, ack, err);
  modport slave(input cyc, stb, we, adr, sel, mosi, output miso, ack, err);
endinterface

// File: rtl/wb_timeout.sv
// wb_timeout: loadable down-counter with clear/enable; expired while the count sits at zero.
module wb_timeout #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone classic initiator copying a block of words, one read then one write per word.
module wb_copy_master
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_adr,
  input  logic [ADDR_WIDTH-1:0] dst_adr,
  input  logic [LEN_WIDTH-1:0]  len_words,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_adr,
  wb_if.master                  wb
);
  localparam int WW = ADDR_WIDTH - 2;
  localparam int TW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  copy_state_e state_q, state_d;
  logic [WW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [WB_DW-1:0] mosi_q, mosi_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d, err_adr_q, err_adr_d;
  logic cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic tmo_load, tmo_exp, fail, unused_low;
  // Loaded with TIMEOUT-1 so the last permitted wait cycle is the one that sees zero.
  wb_timeout #(.W(TW)) u_tmo (
    .clk(sys_clk), .rst_n(sys_rst_n), .clr(1'b0), .load(tmo_load), .en(stb_q),
    .load_val(TW'(TIMEOUT - 1)), .expired(tmo_exp)
  );
  assign fail = (state_q == RD || state_q == WR) && (wb.err || (!wb.ack && tmo_exp && TIMEOUT != 0));
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    mosi_d = mosi_q;
    adr_d = adr_q;
    err_adr_d = err_adr_q;
    cyc_d = cyc_q;
    stb_d = stb_q;
    we_d = we_q;
    busy_d = busy_q;
    done_d = 1'b0;
    error_d = error_q;
    tmo_load = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        src_d = src_adr[ADDR_WIDTH-1:2];
        dst_d = dst_adr[ADDR_WIDTH-1:2];
        cnt_d = len_words;
        error_d = 1'b0;
        busy_d = 1'b1;
        state_d = len_words == '0 ? FIN : RD;
        cyc_d = len_words != '0;
        stb_d = len_words != '0;
        we_d = 1'b0;
        adr_d = {src_adr[ADDR_WIDTH-1:2], 2'b00};
        tmo_load = 1'b1;
      end
      RD: if (wb.ack) begin
        mosi_d = wb.miso;
        cyc_d = 1'b0;
        stb_d = 1'b0;
        state_d = RD_GAP;
      end
      RD_GAP: begin
        state_d = WR;
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d = 1'b1;
        adr_d = {dst_q, 2'b00};
        tmo_load = 1'b1;
      end
      WR: if (wb.ack) begin
        src_d = src_q + 1'b1;
        dst_d = dst_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
        cyc_d = 1'b0;
        stb_d = 1'b0;
        we_d = 1'b0;
        state_d = WR_GAP;
      end
      WR_GAP: if (cnt_q != '0) begin
        state_d = RD;
        cyc_d = 1'b1;
        stb_d = 1'b1;
        adr_d = {src_q, 2'b00};
        tmo_load = 1'b1;
      end else state_d = FIN;
      FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fail) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      we_d = 1'b0;
      error_d = 1'b1;
      err_adr_d = adr_q;
      state_d = FIN;
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      mosi_q <= '0;
      adr_q <= '0;
      err_adr_q <= '0;
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
      mosi_q <= mosi_d;
      adr_q <= adr_d;
      err_adr_q <= err_adr_d;
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      we_q <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  assign wb.cyc = cyc_q;
  assign wb.stb = stb_q;
  assign wb.we = we_q;
  assign wb.adr = adr_q;
  assign wb.sel = WB_SEL_ALL;
  assign wb.mosi = mosi_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign err_adr = err_adr_q;
  assign unused_low = ^{src_adr[1:0], dst_adr[1:0]};
endmodule

// File: tb/tb_wb_copy_master.sv
// tb_wb_copy_master: directed scenarios against a registered ROM/RAM slave that holds ack until stb drops.
module tb_wb_copy_master;
  import wb_pkg::*;
  logic sys_clk = 1'b0, sys_rst_n = 1'b1, start = 1'b0;
  logic [31:0] src_adr = '0, dst_adr = '0, err_adr;
  logic [15:0] len_words = '0;
  logic busy, done, error;
  logic hang = 1'b0, err_on = 1'b0, hit_err, req, found;
  logic [31:0] err_match = '0;
  logic [31:0] ram [0:15];
  logic [31:0] rd_log [0:63];
  int wr_count = 0, rd_count = 0, wr_base, rd_base;
  int busy_n, done_n, done_at, cyc_n, stb_n;
  int pass_n = 0, total_n = 0;
  always #5 sys_clk = ~sys_clk;
  wb_if #(.ADDR_WIDTH(32)) wb ();
  wb_copy_master #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
    .len_words(len_words), .busy(busy), .done(done), .error(error), .err_adr(err_adr), .wb(wb)
  );
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction
  assign req = wb.cyc && wb.stb;
  assign hit_err = err_on && wb.adr == err_match;
  always @(posedge sys_clk) begin
    wb.ack <= req && !hang && !hit_err;
    wb.err <= req && hit_err;
    wb.miso <= rom_word(wb.adr);
    if (req && !wb.ack && !hang && !hit_err) begin
      if (wb.we) begin
        ram[wb.adr[5:2]] <= wb.mosi;
        wr_count <= wr_count + 1;
      end else begin
        rd_log[rd_count[5:0]] <= wb.adr;
        rd_count <= rd_count + 1;
      end
    end
  end
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input int cycles, input int restart_at);
    @(negedge sys_clk);
    wr_base = wr_count;
    rd_base = rd_count;
    start = 1'b1; src_adr = s; dst_adr = d; len_words = n;
    @(negedge sys_clk);
    start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; cyc_n = 0; stb_n = 0;
    for (int i = 1; i <= cycles; i++) begin
      if (busy) busy_n++;
      if (wb.cyc) cyc_n++;
      if (wb.stb) stb_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      start = i == restart_at;
      if (i == restart_at) len_words = 16'd5;
      @(negedge sys_clk);
    end
    start = 1'b0;
  endtask
  task automatic test_reset();
    #1 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    total_n++; if ({wb.cyc, wb.stb, wb.we} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {wb.cyc, wb.stb, wb.we}); else pass_n++;
    total_n++; if (wb.adr !== 32'h0) $display("FAIL reset_adr got %h want 0", wb.adr); else pass_n++;
    total_n++; if (wb.mosi !== 32'h0) $display("FAIL reset_mosi got %h want 0", wb.mosi); else pass_n++;
    total_n++; if (wb.sel !== 4'hF) $display("FAIL reset_sel got %h want f", wb.sel); else pass_n++;
    total_n++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_status got %b want 000", {busy, done, error}); else pass_n++;
    total_n++; if (err_adr !== 32'h0) $display("FAIL reset_err_adr got %h want 0", err_adr); else pass_n++;
    sys_rst_n = 1'b1;
  endtask
  task automatic test_copy4();
    run(32'h0, 32'h1000_0000, 16'd4, 32, 0);
    total_n++; if (busy_n !== 25) $display("FAIL copy4_busy got %0d want 25", busy_n); else pass_n++;
    total_n++; if (done_n !== 1) $display("FAIL copy4_done_count got %0d want 1", done_n); else pass_n++;
    total_n++; if (done_at !== 26) $display("FAIL copy4_done_at got %0d want 26", done_at); else pass_n++;
    total_n++; if (error !== 1'b0) $display("FAIL copy4_error got %b want 0", error); else pass_n++;
    total_n++; if (wr_count - wr_base !== 4) $display("FAIL copy4_writes got %0d want 4", wr_count - wr_base); else pass_n++;
    for (int i = 0; i < 4; i++) begin
      total_n++;
      if (ram[i[3:0]] !== rom_word(32'(4 * i))) $display("FAIL copy4_ram%0d got %h want %h", i, ram[i[3:0]], rom_word(32'(4 * i)));
      else pass_n++;
    end
  endtask
  task automatic test_zero_len();
    run(32'h40, 32'h1000_0000, 16'd0, 8, 0);
    total_n++; if (busy_n !== 1) $display("FAIL zero_busy got %0d want 1", busy_n); else pass_n++;
    total_n++; if (done_at !== 2) $display("FAIL zero_done_at got %0d want 2", done_at); else pass_n++;
    total_n++; if (done_n !== 1) $display("FAIL zero_done_count got %0d want 1", done_n); else pass_n++;
    total_n++; if (cyc_n !== 0) $display("FAIL zero_cyc got %0d want 0", cyc_n); else pass_n++;
  endtask
  task automatic test_wb_err();
    err_on = 1'b1;
    err_match = 32'h1000_0008;
    run(32'h100, 32'h1000_0000, 16'd4, 30, 0);
    err_on = 1'b0;
    total_n++; if (error !== 1'b1) $display("FAIL err_flag got %b want 1", error); else pass_n++;
    total_n++; if (err_adr !== 32'h1000_0008) $display("FAIL err_adr got %h want 10000008", err_adr); else pass_n++;
    total_n++; if (done_n !== 1) $display("FAIL err_done_count got %0d want 1", done_n); else pass_n++;
    total_n++; if (done_at !== 19) $display("FAIL err_done_at got %0d want 19", done_at); else pass_n++;
    total_n++; if (wr_count - wr_base !== 2) $display("FAIL err_writes got %0d want 2", wr_count - wr_base); else pass_n++;
    total_n++; if (ram[0] !== rom_word(32'h100)) $display("FAIL err_ram0 got %h want %h", ram[0], rom_word(32'h100)); else pass_n++;
    total_n++; if (ram[1] !== rom_word(32'h104)) $display("FAIL err_ram1 got %h want %h", ram[1], rom_word(32'h104)); else pass_n++;
  endtask
  task automatic test_timeout();
    hang = 1'b1;
    run(32'h200, 32'h1000_0000, 16'd1, 16, 0);
    hang = 1'b0;
    total_n++; if (stb_n !== 8) $display("FAIL tmo_stb_cycles got %0d want 8", stb_n); else pass_n++;
    total_n++; if (error !== 1'b1) $display("FAIL tmo_error got %b want 1", error); else pass_n++;
    total_n++; if (err_adr !== 32'h200) $display("FAIL tmo_err_adr got %h want 200", err_adr); else pass_n++;
    total_n++; if (done_at !== 10) $display("FAIL tmo_done_at got %0d want 10", done_at); else pass_n++;
    total_n++; if (wr_count - wr_base !== 0) $display("FAIL tmo_writes got %0d want 0", wr_count - wr_base); else pass_n++;
  endtask
  task automatic test_wrap();
    run(32'hFFFF_FFFE, 32'h1000_0020, 16'd2, 20, 3);
    total_n++; if (busy_n !== 13) $display("FAIL wrap_busy got %0d want 13", busy_n); else pass_n++;
    total_n++; if (done_n !== 1) $display("FAIL wrap_done_count got %0d want 1", done_n); else pass_n++;
    total_n++; if (error !== 1'b0) $display("FAIL wrap_error got %b want 0", error); else pass_n++;
    total_n++; if (rd_count - rd_base !== 2) $display("FAIL wrap_reads got %0d want 2", rd_count - rd_base); else pass_n++;
    total_n++; if (rd_log[rd_base[5:0]] !== 32'hFFFF_FFFC) $display("FAIL wrap_rd0 got %h want fffffffc", rd_log[rd_base[5:0]]); else pass_n++;
    total_n++; if (rd_log[6'(rd_base + 1)] !== 32'h0) $display("FAIL wrap_rd1 got %h want 0", rd_log[6'(rd_base + 1)]); else pass_n++;
    total_n++; if (ram[8] !== rom_word(32'hFFFF_FFFC)) $display("FAIL wrap_ram8 got %h want %h", ram[8], rom_word(32'hFFFF_FFFC)); else pass_n++;
    total_n++; if (ram[9] !== rom_word(32'h0)) $display("FAIL wrap_ram9 got %h want %h", ram[9], rom_word(32'h0)); else pass_n++;
  endtask
  task automatic test_reset_mid();
    @(negedge sys_clk);
    start = 1'b1; src_adr = 32'h300; dst_adr = 32'h1000_0030; len_words = 16'd2;
    @(negedge sys_clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wb.we && wb.stb) begin
        found = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    total_n++; if (found !== 1'b1) $display("FAIL rstmid_reach_wr got %b want 1", found); else pass_n++;
    #1 sys_rst_n = 1'b0;
    #1;
    total_n++; if ({wb.cyc, wb.stb} !== 2'b00) $display("FAIL rstmid_cyc got %b want 00", {wb.cyc, wb.stb}); else pass_n++;
    total_n++; if (dut.state_q !== IDLE) $display("FAIL rstmid_state got %0d want %0d", dut.state_q, IDLE); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_n++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run(32'h400, 32'h1000_0040, 16'd1, 10, 0);
    total_n++; if (busy_n !== 7) $display("FAIL rstmid_copy_busy got %0d want 7", busy_n); else pass_n++;
    total_n++; if (done_at !== 8) $display("FAIL rstmid_copy_done_at got %0d want 8", done_at); else pass_n++;
    total_n++; if (error !== 1'b0) $display("FAIL rstmid_copy_error got %b want 0", error); else pass_n++;
    total_n++; if (ram[0] !== rom_word(32'h400)) $display("FAIL rstmid_copy_ram got %h want %h", ram[0], rom_word(32'h400)); else pass_n++;
  endtask
  initial begin
    test_reset();
    test_copy4();
    test_zero_len();
    test_wb_err();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
